// File: rtl/mtm_column_reader.sv
// mtm_column_reader
//   Collects a NUM_PE x NUM_PE tile one row at a time, then presents it one
//   column at a time, which transposes the tile. Filling and draining never
//   overlap. After the last row is accepted, the first column is valid on the
//   next cycle.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_val     : input_row valid
//   in_rdy     : block can accept a row (FILL state)
//   input_row  : one tile row; element j is column j
//   out_val    : output_col valid (DRAIN state)
//   out_rdy    : downstream accepts output_col
//   output_col : one tile column; element i is row i; zero when out_val=0
//   out_last   : high with out_val on the final column of a tile
module mtm_column_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] input_row  [0:NUM_PE-1],
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] output_col [0:NUM_PE-1],
  output logic                  out_last
);

  localparam int               CNT_W   = $clog2(NUM_PE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PE - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      row_cnt, col_cnt;
  logic [DATA_WIDTH-1:0] tile [0:NUM_PE-1][0:NUM_PE-1];
  logic                  fill_acc, drain_acc;

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    out_last   = 1'b0;
    case (state)
      FILL: begin
        in_rdy = 1'b1;
        if (in_val && (row_cnt == CNT_MAX)) state_next = DRAIN;
      end
      DRAIN: begin
        out_val  = 1'b1;
        out_last = (col_cnt == CNT_MAX);
        if (out_rdy && (col_cnt == CNT_MAX)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  assign fill_acc  = in_val && in_rdy;
  assign drain_acc = out_val && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Counters clear explicitly at their end value rather than relying on
  // natural power-of-two wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      if (fill_acc) begin
        if (row_cnt == CNT_MAX) row_cnt <= '0;
        else                    row_cnt <= row_cnt + 1'b1;
      end
      if (drain_acc) begin
        if (col_cnt == CNT_MAX) col_cnt <= '0;
        else                    col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Tile storage has no reset; its contents are only shown after a complete fill.
  always_ff @(posedge clk) begin
    if (!rst && fill_acc) begin
      tile[row_cnt] <= input_row;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      output_col[i] = out_val ? tile[i][col_cnt] : '0;
    end
  end

endmodule

// File: tb/tb_mtm_column_reader.sv
// Self-checking bench for mtm_column_reader (NUM_PE=4, DATA_WIDTH=16).
// The reference model records the rows the bench hands over during FILL.
// Each expected column k is element k taken from every stored row.
module tb_mtm_column_reader;

  localparam int NP = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [DW-1:0] input_row  [0:NP-1];
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] output_col [0:NP-1];
  logic          out_last;

  int passed = 0;
  int total  = 0;

  // Reference model: rows of the tile currently being transferred
  logic [DW-1:0] tile_rows [0:NP-1][0:NP-1];

  mtm_column_reader #(
    .DATA_WIDTH(DW),
    .NUM_PE    (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .input_row (input_row),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .output_col(output_col),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NP*DW-1:0] pack(input logic [DW-1:0] a [0:NP-1]);
    logic [NP*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = a[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic random_row();
    for (int j = 0; j < NP; j++) input_row[j] = DW'($urandom);
  endtask

  // Fills one tile from tile_rows, then drains it and checks every cycle.
  // gap_mode: 0 none, 1 one idle cycle between rows, 2 random 0..2 idles
  // rdy_mode: 0 always ready, 1 toggle 0,1,0,1..., 2 random
  // junk:     drive in_val=1 with random rows throughout DRAIN
  task automatic run_tile(input int gap_mode, input int rdy_mode, input bit junk);
    logic [DW-1:0] exp_col [0:NP-1];
    logic [DW-1:0] zero_col [0:NP-1];
    int k;
    int budget;
    int gaps;
    for (int i = 0; i < NP; i++) zero_col[i] = '0;
    out_rdy = 1'b0;
    for (int r = 0; r < NP; r++) begin
      gaps = (gap_mode == 1) ? ((r == 0) ? 0 : 1) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_val = 1'b0;
        random_row();
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0)
          $display("FAIL fill_gap in_rdy=%b out_val=%b required in_rdy=1 out_val=0", in_rdy, out_val);
        else passed++;
        step();
      end
      in_val    = 1'b1;
      input_row = tile_rows[r];
      @(negedge clk);
      total++;
      if (in_rdy !== 1'b1 || out_val !== 1'b0 || pack(output_col) !== pack(zero_col))
        $display("FAIL fill_row%0d in_rdy=%b out_val=%b col=%h required in_rdy=1 out_val=0 col=0",
                 r, in_rdy, out_val, pack(output_col));
      else passed++;
      step();
    end
    in_val = junk;
    if (junk) random_row();
    k = 0;
    budget = 0;
    while (k < NP && budget < 40) begin
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = budget[0];
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      if (junk) random_row();
      for (int i = 0; i < NP; i++) exp_col[i] = tile_rows[i][k];
      @(negedge clk);
      total++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || pack(output_col) !== pack(exp_col) ||
          out_last !== (k == NP - 1))
        $display("FAIL drain_col%0d out_val=%b in_rdy=%b col=%h last=%b required out_val=1 in_rdy=0 col=%h last=%b",
                 k, out_val, in_rdy, pack(output_col), out_last, pack(exp_col), (k == NP - 1));
      else passed++;
      if (out_rdy) k++;
      budget++;
      step();
    end
    if (k < NP) begin
      total++;
      $display("FAIL drain_timeout got %0d columns required %0d", k, NP);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 || out_last !== 1'b0 || pack(output_col) !== pack(zero_col))
      $display("FAIL after_drain in_rdy=%b out_val=%b last=%b col=%h required 1 0 0 0",
               in_rdy, out_val, out_last, pack(output_col));
    else passed++;
    step();
    out_rdy = 1'b0;
  endtask

  task automatic load_counting_rows();
    for (int r = 0; r < NP; r++)
      for (int j = 0; j < NP; j++) tile_rows[r][j] = DW'(r * NP + j);
  endtask

  task automatic load_random_rows();
    for (int r = 0; r < NP; r++)
      for (int j = 0; j < NP; j++) tile_rows[r][j] = DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b0;
    random_row();
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (in_rdy !== 1'b1 || out_val !== 1'b0 || out_last !== 1'b0 || output_col[0] !== '0 ||
          output_col[NP-1] !== '0)
        $display("FAIL reset_idle%0d in_rdy=%b out_val=%b last=%b col0=%h required 1 0 0 0",
                 c, in_rdy, out_val, out_last, output_col[0]);
      else passed++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    load_counting_rows();
    run_tile(0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    load_counting_rows();
    run_tile(0, 1, 1'b0);
  endtask

  task automatic test_drain_ignore();
    load_random_rows();
    run_tile(0, 1, 1'b1);
    load_random_rows();
    run_tile(0, 0, 1'b0);
  endtask

  task automatic test_reset_abort();
    // Partial fill, then reset while a row handshake is offered
    for (int r = 0; r < 2; r++) begin
      in_val = 1'b1;
      random_row();
      step();
    end
    rst = 1'b1;
    random_row();
    step();
    rst = 1'b0;
    in_val = 1'b0;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0)
      $display("FAIL abort_fill in_rdy=%b out_val=%b required 1 0", in_rdy, out_val);
    else passed++;
    step();
    load_random_rows();
    run_tile(0, 0, 1'b0);
    // Reset in the middle of a drain
    for (int r = 0; r < NP; r++) begin
      in_val = 1'b1;
      random_row();
      step();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 || output_col[1] !== '0)
      $display("FAIL abort_drain in_rdy=%b out_val=%b col1=%h required 1 0 0", in_rdy, out_val, output_col[1]);
    else passed++;
    step();
    load_random_rows();
    run_tile(2, 2, 1'b0);
  endtask

  task automatic test_gaps();
    load_counting_rows();
    run_tile(1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      load_random_rows();
      run_tile(2, 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b0;
    for (int j = 0; j < NP; j++) input_row[j] = '0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_drain_ignore();
    test_reset_abort();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
